// File: rtl/proc_host_pkg.sv
// proc_host_pkg: shared state encoding, fixed timing constants and width helpers
// for the host-side processor sequencer.
package proc_host_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PRST,
    S_REQ,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // Cycles the processor is held in reset after LOAD, before the request.
  localparam int PRST_LEN = 2;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;

  // Bits needed to hold values 0..n (never less than 1).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/proc_host_wdog.sv
// proc_host_wdog: RUN-cycle watchdog. Counts enabled cycles after a clear and
// flags the cycle in which the LIMIT-th enabled cycle is reached (LIMIT >= 1).
module proc_host_wdog
  import proc_host_pkg::*;
#(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = cnt_w(LIMIT);

  logic [CW-1:0] cnt_q;

  // expired is high during the LIMIT-th enabled cycle so the FSM leaves right after it
  assign expired = enable && (cnt_q == CW'(LIMIT - 1));

  // cycle counter, saturates once expired
  always_ff @(posedge clk) begin
    if (!reset)                 cnt_q <= '0;
    else if (clear)             cnt_q <= '0;
    else if (enable && !expired) cnt_q <= cnt_q + CW'(1);
  end

endmodule

// File: rtl/proc_host.sv
// proc_host: host-side sequencer. Preloads data memory from a byte stream with
// the processor held in reset, pulses req, waits for done, then streams a result
// region back out. Optional RUN watchdog under macro PROC_HOST_TIMEOUT_EN.
module proc_host
  import proc_host_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int LOAD_BASE = 0,
  parameter int LOAD_LEN  = 64,
  parameter int RES_BASE  = 64,
  parameter int RES_LEN   = 16,
  parameter int TIMEOUT   = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [DW-1:0] ld_data,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          proc_rst,
  output logic          proc_req,
  input  logic          proc_done,
  output logic          mem_sel,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          finished,
  output logic          timeout
);

  // idx doubles as the PRST cycle counter, so it must also cover PRST_LEN.
  localparam int MAXLEN0 = (LOAD_LEN > RES_LEN) ? LOAD_LEN : RES_LEN;
  localparam int MAXLEN  = (MAXLEN0 > PRST_LEN) ? MAXLEN0 : PRST_LEN;
  localparam int IW      = cnt_w(MAXLEN);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          finished_q;
  logic          wd_expired;
  logic          running;

`ifdef PROC_HOST_TIMEOUT_EN
  logic timeout_q;

  proc_host_wdog #(.LIMIT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == S_REQ),
    .enable  (state_q == S_RUN),
    .expired (wd_expired)
  );

  // timeout flag: set on a watchdog exit from RUN, cleared by an accepted start
  always_ff @(posedge clk) begin
    if (!reset)                                    timeout_q <= 1'b0;
    else if (state_q == S_IDLE && start)           timeout_q <= 1'b0;
    else if (state_q == S_RUN && !proc_done && wd_expired) timeout_q <= 1'b1;
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign wd_expired     = 1'b0;
  assign timeout        = 1'b0;
`endif

  // next-state and idx update; zero-length LOAD/DRAIN phases are skipped
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (start) state_d = (LOAD_LEN == 0) ? S_PRST : S_LOAD;
      end
      S_LOAD: begin
        if (ld_valid) begin
          if (idx_q == IW'(LOAD_LEN - 1)) begin
            state_d = S_PRST;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_PRST: begin
        if (idx_q == IW'(PRST_LEN - 1)) begin
          state_d = S_REQ;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_REQ: state_d = S_RUN;
      S_RUN: begin
        if (proc_done)       state_d = (RES_LEN == 0) ? S_DONE : S_DRAIN;
        else if (wd_expired) state_d = S_DONE;
      end
      S_DRAIN: begin
        if (res_ready) begin
          if (idx_q == IW'(RES_LEN - 1)) begin
            state_d = S_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state, idx and finished flag registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      finished_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == S_IDLE && start)                finished_q <= 1'b0;
      else if (state_d == S_DONE && state_q != S_DONE) finished_q <= 1'b1;
    end
  end

  // memory address: load or drain window offset by idx, wrapping mod 2^AW
  always_comb begin
    mem_addr = '0;
    case (state_q)
      S_LOAD:  mem_addr = AW'(LOAD_BASE) + AW'(idx_q);
      S_DRAIN: mem_addr = AW'(RES_BASE) + AW'(idx_q);
      default: mem_addr = '0;
    endcase
  end

  // The processor only sees memory and comes out of reset in REQ/RUN.
  assign running   = (state_q == S_REQ) || (state_q == S_RUN);
  assign proc_rst  = !running;
  assign mem_sel   = !running;
  assign proc_req  = (state_q == S_REQ);
  assign ld_ready  = (state_q == S_LOAD);
  assign mem_wr_en = ld_ready && ld_valid;
  assign mem_wdata = ld_data;
  assign res_valid = (state_q == S_DRAIN);
  assign res_data  = mem_rdata;
  assign busy      = (state_q != S_IDLE);
  assign finished  = finished_q;

endmodule

// File: tb/tb_proc_host.sv
// tb_proc_host: directed bench for proc_host. A main instance (load 0x10, 4 bytes;
// drain 0x40, 2 bytes) runs against a small memory/processor model; a second
// instance with LOAD_BASE=0xFE and TIMEOUT=8 shares the stimulus to cover
// address wrap and the RUN watchdog (never sees done).
module tb_proc_host;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, ld_valid, res_ready, proc_done;
  logic [7:0] ld_data;

  logic       ld_ready, res_valid, proc_rst, proc_req, mem_sel, mem_wr_en;
  logic       busy, finished, timeout;
  logic [7:0] res_data, mem_addr, mem_wdata, mem_rdata;

  logic       w_ld_ready, w_res_valid, w_proc_rst, w_proc_req, w_mem_sel, w_mem_wr_en;
  logic       w_busy, w_finished, w_timeout;
  logic [7:0] w_res_data, w_mem_addr, w_mem_wdata;

  logic       proc_we;
  logic [7:0] proc_addr, proc_wdata;
  logic [7:0] mem [256];

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int hs_cnt = 0;
  int w_rv_cnt = 0;

  proc_host #(.AW(8), .DW(8), .LOAD_BASE(8'h10), .LOAD_LEN(4), .RES_BASE(8'h40),
              .RES_LEN(2), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .start(start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .proc_rst(proc_rst), .proc_req(proc_req), .proc_done(proc_done),
    .mem_sel(mem_sel), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .finished(finished), .timeout(timeout)
  );

  proc_host #(.AW(8), .DW(8), .LOAD_BASE(8'hFE), .LOAD_LEN(4), .RES_BASE(8'h40),
              .RES_LEN(2), .TIMEOUT(8)) dut_w (
    .clk(clk), .reset(reset), .start(start),
    .ld_valid(ld_valid), .ld_ready(w_ld_ready), .ld_data(ld_data),
    .res_valid(w_res_valid), .res_ready(res_ready), .res_data(w_res_data),
    .proc_rst(w_proc_rst), .proc_req(w_proc_req), .proc_done(1'b0),
    .mem_sel(w_mem_sel), .mem_wr_en(w_mem_wr_en), .mem_addr(w_mem_addr),
    .mem_wdata(w_mem_wdata), .mem_rdata(8'h00),
    .busy(w_busy), .finished(w_finished), .timeout(w_timeout)
  );

  // wrapper memory: host port when mem_sel, processor-model port otherwise
  always @(posedge clk) begin
    if (mem_sel && mem_wr_en)    mem[mem_addr]  <= mem_wdata;
    else if (!mem_sel && proc_we) mem[proc_addr] <= proc_wdata;
  end
  assign mem_rdata = mem_sel ? mem[mem_addr] : 8'h00;

  // event monitors
  always @(posedge clk) begin
    if (proc_req)               req_cnt  <= req_cnt + 1;
    if (res_valid && res_ready) hs_cnt   <= hs_cnt + 1;
    if (w_res_valid)            w_rv_cnt <= w_rv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] e;
    reset = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
    res_ready = 1'b0; proc_done = 1'b0;
    proc_we = 1'b0; proc_addr = 8'h00; proc_wdata = 8'h00;
    tick(); tick();

    // reset state
    chk("rst_proc_rst", proc_rst, 1);
    chk("rst_mem_sel", mem_sel, 1);
    chk("rst_proc_req", proc_req, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_mem_wr_en", mem_wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_finished", finished, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_mem_addr", mem_addr, 0);

    reset = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // job 1: start -> LOAD next cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_ld_ready", ld_ready, 1);
    chk("load_w_ld_ready", w_ld_ready, 1);
    chk("load_busy", busy, 1);
    chk("load_proc_rst", proc_rst, 1);

    ld_valid = 1'b1; ld_data = 8'hA1;
    #1;
    chk("beat0_wr_en", mem_wr_en, 1);
    chk("beat0_addr", mem_addr, 8'h10);
    chk("beat0_wdata", mem_wdata, 8'hA1);
    chk("beat0_w_addr", w_mem_addr, 8'hFE);
    chk("beat0_w_wr_en", w_mem_wr_en, 1);
    chk("beat0_w_wdata", w_mem_wdata, 8'hA1);
    tick();

    // one-cycle gap: no write, address held
    ld_valid = 1'b0;
    #1;
    chk("gap_wr_en", mem_wr_en, 0);
    chk("gap_addr", mem_addr, 8'h11);
    chk("gap_ld_ready", ld_ready, 1);
    chk("gap_proc_rst", proc_rst, 1);
    tick();

    for (int i = 1; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = 8'hA1 + 8'(i);
      #1;
      e = 8'h10 + 8'(i);
      chk("beat_addr", mem_addr, e);
      chk("beat_wr_en", mem_wr_en, 1);
      e = 8'hFE + 8'(i);
      chk("beat_w_addr_wrap", w_mem_addr, e);
      tick();
    end
    ld_valid = 1'b0;

    // PRST: two cycles in reset, then REQ, then RUN
    chk("prst1_ld_ready", ld_ready, 0);
    chk("prst1_proc_rst", proc_rst, 1);
    chk("prst1_mem_sel", mem_sel, 1);
    chk("prst1_proc_req", proc_req, 0);
    tick();
    chk("prst2_proc_rst", proc_rst, 1);
    chk("prst2_proc_req", proc_req, 0);
    tick();
    chk("req_proc_req", proc_req, 1);
    chk("req_proc_rst", proc_rst, 0);
    chk("req_mem_sel", mem_sel, 0);
    chk("req_w_proc_req", w_proc_req, 1);
    tick();
    chk("run_proc_req", proc_req, 0);
    chk("run_proc_rst", proc_rst, 0);
    chk("run_busy", busy, 1);
    chk("mem10", mem[8'h10], 8'hA1);
    chk("mem11", mem[8'h11], 8'hA2);
    chk("mem12", mem[8'h12], 8'hA3);
    chk("mem13", mem[8'h13], 8'hA4);

    // RUN cycles 1 and 2: processor model writes the result region
    proc_we = 1'b1; proc_addr = 8'h40; proc_wdata = 8'h5A;
    tick();
    proc_addr = 8'h41; proc_wdata = 8'hC3;
    tick();
    proc_we = 1'b0;
    for (int r = 3; r < 20; r++) begin
`ifdef PROC_HOST_TIMEOUT_EN
      if (r == 8) begin
        chk("wd_r8_finished", w_finished, 0);
        chk("wd_r8_timeout", w_timeout, 0);
        chk("wd_r8_proc_rst", w_proc_rst, 0);
      end
      if (r == 9) begin
        chk("wd_done_finished", w_finished, 1);
        chk("wd_done_timeout", w_timeout, 1);
        chk("wd_done_busy", w_busy, 1);
      end
      if (r == 10) begin
        chk("wd_idle_busy", w_busy, 0);
        chk("wd_idle_mem_sel", w_mem_sel, 1);
        chk("wd_idle_timeout", w_timeout, 1);
      end
`endif
      tick();
    end
`ifndef PROC_HOST_TIMEOUT_EN
    chk("norun_timeout_busy", w_busy, 1);
    chk("norun_timeout_proc_rst", w_proc_rst, 0);
    chk("norun_timeout_mem_sel", w_mem_sel, 0);
    chk("norun_timeout_flag", w_timeout, 0);
`endif
    chk("w_no_res_valid", w_rv_cnt, 0);
    chk("w_res_data", w_res_data, 8'h00);

    // RUN cycle 20: done
    chk("run20_res_valid", res_valid, 0);
    chk("run20_busy", busy, 1);
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    chk("req_single_pulse", req_cnt, 1);

    // DRAIN beat 0 accepted at once, beat 1 stalled 3 cycles
    res_ready = 1'b1;
    #1;
    chk("drain0_valid", res_valid, 1);
    chk("drain0_data", res_data, 8'h5A);
    chk("drain0_addr", mem_addr, 8'h40);
    chk("drain0_mem_sel", mem_sel, 1);
    chk("drain0_proc_rst", proc_rst, 1);
    tick();
    res_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk("stall_valid", res_valid, 1);
      chk("stall_data", res_data, 8'hC3);
      chk("stall_addr", mem_addr, 8'h41);
      tick();
    end
    res_ready = 1'b1;
    #1;
    chk("drain1_data", res_data, 8'hC3);
    tick();
    res_ready = 1'b0;
    chk("done_finished", finished, 1);
    chk("done_busy", busy, 1);
    chk("done_res_valid", res_valid, 0);
    chk("drain_handshakes", hs_cnt, 2);
    tick();
    chk("idle2_busy", busy, 0);
    chk("idle2_finished", finished, 1);
    chk("idle2_proc_rst", proc_rst, 1);

    // job 2: aborted by reset during RUN
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("job2_finished_clr", finished, 0);
    ld_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ld_data = 8'hD0 + 8'(i);
      tick();
    end
    ld_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("job2_run_proc_rst", proc_rst, 0);
    reset = 1'b0;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_proc_rst", proc_rst, 1);
    chk("abort_mem_sel", mem_sel, 1);
    chk("abort_finished", finished, 0);
    chk("abort_timeout", timeout, 0);
    chk("abort_proc_req", proc_req, 0);
    chk("abort_mem_addr", mem_addr, 0);
    reset = 1'b1;
    tick();

    // job 3: clean run after abort, done on first RUN cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("job3_ld_ready", ld_ready, 1);
    chk("job3_addr_from0", mem_addr, 8'h10);
    ld_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ld_data = 8'hB1 + 8'(i);
      tick();
    end
    ld_valid = 1'b0;
    tick(); tick(); tick();
    chk("job3_run_proc_rst", proc_rst, 0);
    chk("job3_req_count", req_cnt, 3);
    chk("job3_mem10", mem[8'h10], 8'hB1);
    chk("job3_mem13", mem[8'h13], 8'hB4);
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    res_ready = 1'b1;
    #1;
    chk("job3_drain0", res_data, 8'h5A);
    tick();
    chk("job3_drain1", res_data, 8'hC3);
    chk("job3_drain1_addr", mem_addr, 8'h41);
    tick();
    res_ready = 1'b0;
    chk("job3_finished", finished, 1);
    chk("job3_handshakes", hs_cnt, 4);
    tick();
    chk("job3_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
